// File: rtl/regfile_wb_pkg.sv
// Shared types and sizes for the register-file write-back arbiter.
// Both the top module and its FIFO import this package.
package regfile_wb_pkg;

  localparam int XLEN       = 32;
  localparam int AW         = 5;
  localparam int DEF_QDEPTH = 4;
  localparam int DEF_STARVE = 8;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries for the long-latency result path.
// Push while full and pop while empty are ignored.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = DEF_QDEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  logic      pop_i,
  input  wb_entry_t entry_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Depth is a power of two, so the pointers wrap by plain overflow.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: merges ALU and buffered long-latency results onto the
// single register-file write port and keeps the busy scoreboard for hazards.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int QDEPTH = DEF_QDEPTH,
  parameter int STARVE = DEF_STARVE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic            iss_long,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            hazard,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_hold,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            RegWrite,
  output logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] write_data
);

  localparam int AGE_W = $clog2(STARVE + 1);
  localparam int NREG  = 2 ** AW;

  wb_entry_t        head, b_entry;
  logic             full, empty, starve, take_a, pop;
  logic [AGE_W-1:0] age_q, age_d;
  logic             we_q, we_d, from_b_q, from_b_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [NREG-1:0]  busy_q, busy_d;

  assign b_entry = '{rd: b_rd, data: b_data};

  wb_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (b_valid),
    .pop_i   (pop),
    .entry_i (b_entry),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  // A starved FIFO head overrides the ALU; a write to x0 from A is not a claim.
  assign starve  = !empty && (age_q == AGE_W'(STARVE));
  assign take_a  = !starve && a_valid && (a_rd != '0);
  assign pop     = !empty && !take_a;
  assign a_hold  = starve;
  assign b_ready = !full;

  assign hazard = ((rs1_addr != '0) && busy_q[rs1_addr]) ||
                  ((rs2_addr != '0) && busy_q[rs2_addr]) ||
                  ((iss_rd   != '0) && busy_q[iss_rd]);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    age_d    = age_q;
    we_d     = 1'b0;
    from_b_d = 1'b0;
    rd_d     = rd_q;
    data_d   = data_q;
    busy_d   = busy_q;

    if (empty || pop)                    age_d = '0;
    else if (age_q != AGE_W'(STARVE))    age_d = age_q + 1'b1;

    if (take_a) begin
      we_d   = 1'b1;
      rd_d   = a_rd;
      data_d = a_data;
    end else if (pop && (head.rd != '0)) begin
      we_d     = 1'b1;
      from_b_d = 1'b1;
      rd_d     = head.rd;
      data_d   = head.data;
    end

    // Clear on the commit edge of a FIFO write; a same-cycle issue re-sets it.
    if (we_q && from_b_q) busy_d[rd_q] = 1'b0;
    if (iss_valid && iss_long && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      age_q    <= '0;
      we_q     <= 1'b0;
      from_b_q <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      busy_q   <= '0;
    end else begin
      age_q    <= age_d;
      we_q     <= we_d;
      from_b_q <= from_b_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
    end
  end

  assign RegWrite   = we_q;
  assign rd_addr    = rd_q;
  assign write_data = data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter: a queue-based model
// predicts each write and a separate monitor compares what the port shows.
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;

  localparam int QD = 4;
  localparam int SV = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            iss_valid, iss_long;
  logic [AW-1:0]   iss_rd, rs1_addr, rs2_addr;
  logic            hazard;
  logic            a_valid;
  logic [AW-1:0]   a_rd;
  logic [XLEN-1:0] a_data;
  logic            a_hold;
  logic            b_valid, b_ready;
  logic [AW-1:0]   b_rd;
  logic [XLEN-1:0] b_data;
  logic            RegWrite;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] write_data;

  regfile_wb_arbiter #(.QDEPTH(QD), .STARVE(SV)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard(hazard),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_hold(a_hold),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .RegWrite(RegWrite), .rd_addr(rd_addr), .write_data(write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rst;
    logic            iss_v, iss_l;
    logic [AW-1:0]   iss_rd, rs1, rs2;
    logic            a_v;
    logic [AW-1:0]   a_rd;
    logic [XLEN-1:0] a_data;
    logic            b_v;
    logic [AW-1:0]   b_rd;
    logic [XLEN-1:0] b_data;
  } stim_t;

  typedef struct {
    int              cyc;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t      exp_q[$];
  wb_entry_t mq[$];
  int        m_age = 0;
  bit        m_busy[32];
  bit        pend_v = 1'b0;
  logic [AW-1:0] pend_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every write the port shows against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'd0, rd_addr}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("write_cycle", 64'(cyc), 64'(e.cyc));
        check("write_rd", {59'd0, rd_addr}, {59'd0, e.rd});
        check("write_data", {32'd0, write_data}, {32'd0, e.data});
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      check("missing_write", 64'(RegWrite === 1'b1), 64'd1);
    end
  end

  function automatic stim_t idle_s();
    stim_t s;
    s = '{rst: 1'b0, iss_v: 1'b0, iss_l: 1'b0, iss_rd: '0, rs1: '0, rs2: '0,
          a_v: 1'b0, a_rd: '0, a_data: '0, b_v: 1'b0, b_rd: '0, b_data: '0};
    return s;
  endfunction

  function automatic bit model_hazard(input stim_t s);
    return (s.rs1 != 0 && m_busy[s.rs1]) || (s.rs2 != 0 && m_busy[s.rs2]) ||
           (s.iss_rd != 0 && m_busy[s.iss_rd]);
  endfunction

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic step(input stim_t s);
    bit        starve, full, was_empty, popped, nb;
    logic [AW-1:0] nrd;
    wb_entry_t e;
    @(negedge clk);
    rst = s.rst; iss_valid = s.iss_v; iss_long = s.iss_l; iss_rd = s.iss_rd;
    rs1_addr = s.rs1; rs2_addr = s.rs2;
    a_valid = s.a_v; a_rd = s.a_rd; a_data = s.a_data;
    b_valid = s.b_v; b_rd = s.b_rd; b_data = s.b_data;
    #1;
    starve    = mq.size() > 0 && m_age == SV;
    full      = mq.size() == QD;
    was_empty = mq.size() == 0;
    check("b_ready", 64'(b_ready), 64'(!full));
    check("a_hold", 64'(a_hold), 64'(starve));
    check("hazard", 64'(hazard), 64'(model_hazard(s)));
    if (s.rst) begin
      mq.delete(); exp_q.delete();
      m_age = 0; pend_v = 1'b0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else begin
      popped = 1'b0; nb = 1'b0; nrd = '0;
      if (starve || !(s.a_v && s.a_rd != 0)) begin
        if (!was_empty) begin
          e = mq.pop_front();
          popped = 1'b1;
          if (e.rd != 0) begin
            exp_q.push_back('{cyc + 1, e.rd, e.data});
            nb = 1'b1; nrd = e.rd;
          end
        end
      end else begin
        exp_q.push_back('{cyc + 1, s.a_rd, s.a_data});
      end
      if (s.b_v && !full) mq.push_back('{rd: s.b_rd, data: s.b_data});
      if (was_empty || popped) m_age = 0;
      else if (m_age < SV)     m_age++;
      if (pend_v) m_busy[pend_rd] = 1'b0;
      if (s.iss_v && s.iss_l && s.iss_rd != 0) m_busy[s.iss_rd] = 1'b1;
      pend_v = nb; pend_rd = nrd;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    int    holds;
    int    a_prob;
    bit    held, starve_now;

    s = idle_s();
    rst = 1'b1; iss_valid = 0; iss_long = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
    a_valid = 0; a_rd = 0; a_data = 0; b_valid = 0; b_rd = 0; b_data = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    repeat (2) @(posedge clk);
    s.rst = 1'b1; step(s);
    step(idle_s());
    check("reset_regwrite", 64'(RegWrite), 64'd0);
    check("reset_rd_addr", {59'd0, rd_addr}, 64'd0);
    check("reset_write_data", {32'd0, write_data}, 64'd0);

    // ALU write, then an ALU write to x0 that must not reach the port.
    s = idle_s(); s.a_v = 1; s.a_rd = 3; s.a_data = 32'hDEADBEEF; step(s);
    step(idle_s());
    check("a_write_en", 64'(RegWrite), 64'd1);
    check("a_write_rd", {59'd0, rd_addr}, 64'd3);
    check("a_write_data", {32'd0, write_data}, 64'hDEADBEEF);
    s = idle_s(); s.a_v = 1; s.a_rd = 0; s.a_data = 32'h1111; step(s);
    step(idle_s());
    check("a_rd0_no_write", 64'(RegWrite), 64'd0);

    // Long op to x5: hazard until the cycle after its B write commits.
    s = idle_s(); s.iss_v = 1; s.iss_l = 1; s.iss_rd = 5; step(s);
    s = idle_s(); s.rs1 = 5; step(s);
    check("raw_hazard", 64'(hazard), 64'd1);
    s.b_v = 1; s.b_rd = 5; s.b_data = 32'h12; step(s);
    s = idle_s(); s.rs1 = 5; step(s);
    step(s);
    check("b_write_en", 64'(RegWrite), 64'd1);
    check("b_write_data", {32'd0, write_data}, 64'h12);
    check("hazard_during_commit", 64'(hazard), 64'd1);
    step(s);
    check("hazard_after_commit", 64'(hazard), 64'd0);

    // Fill the FIFO while the ALU keeps winning, then drain in order.
    for (int k = 0; k < 4; k++) begin
      s = idle_s(); s.a_v = 1; s.a_rd = 1; s.a_data = 32'(k);
      s.b_v = 1; s.b_rd = AW'(8 + k); s.b_data = 32'h100 + 32'(k);
      step(s);
    end
    s = idle_s(); s.a_v = 1; s.a_rd = 1; s.a_data = 32'h55; step(s);
    check("full_b_ready", 64'(b_ready), 64'd0);
    repeat (8) step(idle_s());

    // Starvation: ALU held continuously, one B entry must win after STARVE cycles.
    holds = 0;
    s = idle_s(); s.a_v = 1; s.a_rd = 2; s.a_data = 32'hA0;
    s.b_v = 1; s.b_rd = 9; s.b_data = 32'hB9; step(s);
    s.b_v = 0;
    for (int k = 0; k < 12; k++) begin
      step(s);
      if (a_hold === 1'b1) holds++;
    end
    check("starve_hold_count", 64'(holds), 64'd1);
    repeat (3) step(idle_s());

    // Set and clear of x7 in the same cycle: set wins.
    s = idle_s(); s.iss_v = 1; s.iss_l = 1; s.iss_rd = 7; step(s);
    s = idle_s(); s.b_v = 1; s.b_rd = 7; s.b_data = 32'h77; step(s);
    step(idle_s());
    s = idle_s(); s.iss_v = 1; s.iss_l = 1; s.iss_rd = 7; step(s);
    s = idle_s(); s.rs1 = 7; step(s);
    check("set_wins_hazard", 64'(hazard), 64'd1);
    s = idle_s(); s.b_v = 1; s.b_rd = 7; s.b_data = 32'h78; step(s);
    repeat (3) step(idle_s());
    // B result to x0 is dropped.
    s = idle_s(); s.b_v = 1; s.b_rd = 0; s.b_data = 32'hFF; step(s);
    repeat (3) step(idle_s());

    // Reset with two queued entries and busy bits set.
    s = idle_s(); s.iss_v = 1; s.iss_l = 1; s.iss_rd = 4; step(s);
    s.iss_rd = 6; step(s);
    s = idle_s(); s.a_v = 1; s.a_rd = 1; s.a_data = 32'hC0;
    s.b_v = 1; s.b_rd = 4; s.b_data = 32'h44; step(s);
    s.b_rd = 6; s.b_data = 32'h66; step(s);
    s = idle_s(); s.rst = 1; step(s);
    s = idle_s(); s.rs1 = 4; s.rs2 = 6; s.b_v = 0; step(s);
    check("post_reset_b_ready", 64'(b_ready), 64'd1);
    check("post_reset_hazard", 64'(hazard), 64'd0);
    check("post_reset_regwrite", 64'(RegWrite), 64'd0);

    // Randomised traffic; the ALU producer holds its result while a_hold is seen.
    held = 1'b0;
    a_prob = 7;
    for (int c = 0; c < 3000; c++) begin
      if (c % 60 == 0) a_prob = ($urandom_range(0, 1) == 1) ? 10 : 6;
      starve_now = mq.size() > 0 && m_age == SV;
      if (!held) begin
        s.a_v    = ($urandom_range(0, 9) < a_prob);
        s.a_rd   = AW'($urandom_range(0, 7));
        s.a_data = $urandom;
      end
      s.rst    = ($urandom_range(0, 399) == 0);
      s.b_v    = ($urandom_range(0, 1) == 1);
      s.b_rd   = AW'($urandom_range(0, 7));
      s.b_data = $urandom;
      s.rs1    = AW'($urandom_range(0, 7));
      s.rs2    = AW'($urandom_range(0, 7));
      s.iss_rd = AW'($urandom_range(0, 7));
      s.iss_l  = ($urandom_range(0, 1) == 1);
      s.iss_v  = !model_hazard(s) && ($urandom_range(0, 9) < 4);
      step(s);
      held = s.a_v && starve_now && !s.rst;
    end

    repeat (20) step(idle_s());
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
